// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Brief    : 640x480@60 raster defaults, derived totals/sync bounds, the
//             renderer colour palette and a window-decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Raster counter width; totals up to 1024 fit.
    localparam int c_CNT_W = 10;

    // Horizontal defaults (pixels)
    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FP      = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BP      = 48;

    // Vertical defaults (lines)
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FP      = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BP      = 33;

    // Derived values; sync end is exclusive
    localparam int c_H_TOTAL      = c_H_VISIBLE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL      = c_V_VISIBLE + c_V_FP + c_V_SYNC + c_V_BP;
    localparam int c_H_SYNC_START = c_H_VISIBLE + c_H_FP;
    localparam int c_H_SYNC_END   = c_H_SYNC_START + c_H_SYNC;
    localparam int c_V_SYNC_START = c_V_VISIBLE + c_V_FP;
    localparam int c_V_SYNC_END   = c_V_SYNC_START + c_V_SYNC;

    // 12-bit RGB (4:4:4) colours used by the renderer
    localparam logic [11:0] c_COLOR_BLACK  = 12'h000;
    localparam logic [11:0] c_COLOR_WHITE  = 12'hFFF;
    localparam logic [11:0] c_COLOR_RED    = 12'hF00;
    localparam logic [11:0] c_COLOR_GREEN  = 12'h0F0;
    localparam logic [11:0] c_COLOR_BLUE   = 12'h00F;
    localparam logic [11:0] c_COLOR_YELLOW = 12'hFF0;
    localparam logic [11:0] c_COLOR_GREY   = 12'h888;

    // True when lo <= pos < hi; one extra bit so a bound of 1024 is representable
    function automatic logic in_window(
        input logic [c_CNT_W:0] pos,
        input logic [c_CNT_W:0] lo,
        input logic [c_CNT_W:0] hi
    );
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_clk_en_div.sv
`default_nettype none
// ============================================================================
//  Module   : clk_en_div
//  Brief    : Divides Clk into a one-cycle enable every CLK_DIV cycles.
//             The enable is registered from the cycle in which the divider
//             sits at its terminal count; constant 1 out of reset when
//             CLK_DIV = 1.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic pix_en
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
        $error("clk_en_div: CLK_DIV must be in 1..16");
    end

    logic r_pix_en;

    if (CLK_DIV == 1) begin : g_div_bypass
        // Every cycle is a pixel cycle once out of reset
        always_ff @(posedge Clk) begin
            if (!Reset_n) r_pix_en <= 1'b0;
            else          r_pix_en <= 1'b1;
        end
    end else begin : g_div_count
        localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
        logic [c_DIV_W-1:0] r_div;

        // Wrap the divider and flag the cycle following its terminal count
        always_ff @(posedge Clk) begin
            if (!Reset_n) begin
                r_div    <= '0;
                r_pix_en <= 1'b0;
            end else begin
                r_pix_en <= (r_div == c_DIV_LAST);
                r_div    <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            end
        end
    end

    assign pix_en = r_pix_en;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Brief    : Raster timing generator: pixel enable, h/v counters, active
//             area flag, active-low syncs and line/frame start strobes.
//             Decoded outputs are registered from the next counter values so
//             they line up with the counters on the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FP      = c_H_FP,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BP      = c_H_BP,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FP      = c_V_FP,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BP      = c_V_BP,
    parameter int CLK_DIV   = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    output logic               pix_en,
    output logic [c_CNT_W-1:0] hCount,
    output logic [c_CNT_W-1:0] vCount,
    output logic               bright,
    output logic               hSync,
    output logic               vSync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int c_H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if ((c_H_TOT > 1024) || (c_V_TOT > 1024)) begin : g_bad_raster
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    localparam logic [c_CNT_W-1:0] c_H_LAST   = c_CNT_W'(c_H_TOT - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST   = c_CNT_W'(c_V_TOT - 1);
    localparam logic [c_CNT_W:0]   c_H_VIS    = (c_CNT_W + 1)'(H_VISIBLE);
    localparam logic [c_CNT_W:0]   c_V_VIS    = (c_CNT_W + 1)'(V_VISIBLE);
    localparam logic [c_CNT_W:0]   c_HS_START = (c_CNT_W + 1)'(H_VISIBLE + H_FP);
    localparam logic [c_CNT_W:0]   c_HS_END   = (c_CNT_W + 1)'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [c_CNT_W:0]   c_VS_START = (c_CNT_W + 1)'(V_VISIBLE + V_FP);
    localparam logic [c_CNT_W:0]   c_VS_END   = (c_CNT_W + 1)'(V_VISIBLE + V_FP + V_SYNC);

    logic               w_pix_en;
    logic [c_CNT_W-1:0] r_h_count;
    logic [c_CNT_W-1:0] r_v_count;
    logic               r_bright;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [c_CNT_W-1:0] w_h_next;
    logic [c_CNT_W-1:0] w_v_next;
    logic               w_bright_next;
    logic               w_hsync_next;
    logic               w_vsync_next;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_div (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .pix_en  (w_pix_en)
    );

    // Next raster position and the decodes taken from it
    always_comb begin
        w_h_wrap = (r_h_count == c_H_LAST);
        w_v_wrap = (r_v_count == c_V_LAST);
        w_h_next = w_h_wrap ? '0 : r_h_count + 1'b1;
        w_v_next = r_v_count;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v_count + 1'b1;
        end
        w_bright_next = ({1'b0, w_h_next} < c_H_VIS) && ({1'b0, w_v_next} < c_V_VIS);
        w_hsync_next  = !in_window({1'b0, w_h_next}, c_HS_START, c_HS_END);
        w_vsync_next  = !in_window({1'b0, w_v_next}, c_VS_START, c_VS_END);
    end

    // Advance the raster on pixel enables; strobes last one Clk
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_bright      <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_pix_en) begin
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_bright      <= w_bright_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_h_wrap && w_v_wrap;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign pix_en      = w_pix_en;
    assign hCount      = r_h_count;
    assign vCount      = r_v_count;
    assign bright      = r_bright;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing generator that sits directly upstream of the game/board renderer. It divides the system clock into a pixel-rate enable and produces raster counters `hCount`/`vCount`, the active-area flag `bright`, and active-low `hSync`/`vSync` for a 640x480@60 display. It also emits one-cycle `line_start` and `frame_start` strobes, which give downstream game logic a safe point to update board state.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, Clk cycles per pixel; legal range 1..16

Ports:
- `Clk` in 1: single system clock; all logic on posedge.
- `Reset_n` in 1: synchronous, active-low reset.
- `pix_en` out 1: one-Clk pulse every `CLK_DIV` cycles; constant 1 when `CLK_DIV`=1.
- `hCount` out 10: horizontal position. 0..H_TOTAL-1, where H_TOTAL = 800 at defaults.
- `vCount` out 10: vertical position. 0..V_TOTAL-1, where V_TOTAL = 525 at defaults.
- `bright` out 1: high when hCount<H_VISIBLE and vCount<V_VISIBLE.
- `hSync` out 1: active low.
- `vSync` out 1: active low.
- `line_start` out 1: one-Clk strobe when hCount becomes 0.
- `frame_start` out 1: one-Clk strobe when (hCount,vCount) becomes (0,0).

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pix_en` is registered high during the Clk cycle in which `div`==CLK_DIV-1.
- Counters advance only on Clk edges where `pix_en`=1.
  - hCount: +1. At H_TOTAL-1 it wraps to 0.
  - vCount: +1 only when hCount wraps. At V_TOTAL-1 it wraps to 0.
- Line order: visible, front porch, sync, back porch. Pixel 0 is the first visible pixel.
- `hSync`=0 iff H_VISIBLE+H_FP ≤ hCount < H_VISIBLE+H_FP+H_SYNC. At defaults: 656..751.
- `vSync`=0 iff V_VISIBLE+V_FP ≤ vCount < V_VISIBLE+V_FP+V_SYNC. At defaults: 490..491.
- `bright`, `hSync` and `vSync` are registered. They are decoded from the next counter values, so they always match the counters on the same cycle.
- `line_start` is high for the single Clk cycle after the edge that loads hCount=0. `frame_start` is the same, for the edge that loads (0,0).
- Width rule: H_TOTAL and V_TOTAL must be ≤ 1024. An elaboration-time check fails otherwise.
- No handshake. The renderer samples the outputs combinationally on every Clk.

## Timing
- Reset values, held while `Reset_n`=0:
  - `div`=0, hCount=0, vCount=0
  - bright=0, hSync=1, vSync=1
  - pix_en=0, line_start=0, frame_start=0
- First `pix_en` occurs CLK_DIV cycles after the first Clk edge with `Reset_n`=1.
  - That edge moves hCount to 1; bright becomes 1.
  - bright stays 0 until this edge even though (0,0) is visible. This is accepted.
- No `frame_start` or `line_start` is issued for the post-reset (0,0). The first strobes come at the first natural wrap.
- Line period = H_TOTAL·CLK_DIV Clk cycles: 3200 at defaults.
- Frame period = V_TOTAL·H_TOTAL·CLK_DIV Clk cycles: 1,680,000 at defaults.
- Reset asserted mid-frame: all state returns to reset values on that edge, with no partial strobes. The sequence restarts identically after release.
- `line_start` and `frame_start` coincide at a frame wrap; both are high in the same cycle.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 640x480 default constants;
  - the derived H_TOTAL, V_TOTAL, sync start and sync end values;
  - the 12-bit colour constants used by the renderer.
- One natural sub-module, `clk_en_div` (parameter `CLK_DIV`), generates `pix_en`. Counter, decode and strobe logic stay in `vga_sync_gen`.

## Test plan
- Reset held for 10 cycles, then released:
  - all outputs at their reset values during reset;
  - first `pix_en` at release+4 cycles;
  - `pix_en` period exactly 4 thereafter.
- Run one line at defaults:
  - hSync low on exactly hCount 656..751, 96 pixels;
  - bright low from hCount 640 to 799;
  - `line_start` pulses once per 3200 Clk cycles.
- Run 2 frames:
  - vSync low on exactly vCount 490..491;
  - `frame_start` pulses once per 1,680,000 Clk cycles, each coinciding with a `line_start`;
  - vCount never exceeds 524.
- Reset asserted at hCount=700, vCount=300 for 1 cycle:
  - next cycle shows (0,0), hSync=1, vSync=1, bright=0, no strobe;
  - timing after release matches the post-reset test.
- Parameter override CLK_DIV=1 with a small raster (H 8/1/2/1, V 4/1/1/1):
  - `pix_en` constant 1;
  - hCount wraps 11→0;
  - vCount wraps 6→0;
  - sync windows match the formulas.
